// File: rtl/mul_div_unit.sv
// Signed multi-cycle multiply/divide: done pulses 17 cycles after an accepted start (1 for divide by zero).
// No backpressure: start is ignored while busy and never queued; results hold until the next load.
module mul_div_unit #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result_lo,
  output logic [WIDTH-1:0] o_result_hi,
  output logic             o_div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic               r_op;
  logic               r_neg;
  logic               r_rem_neg;
  logic               r_dbz;
  logic [WIDTH-1:0]   r_opa;
  logic [WIDTH-1:0]   r_opb;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_rem;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_hi;
  logic               r_dz_out;

  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic               w_start_dbz;
  logic [2*WIDTH-1:0] w_addend;
  logic [2*WIDTH-1:0] w_acc_next;
  logic [WIDTH:0]     w_rem_sh;
  logic               w_qbit;
  logic [WIDTH-1:0]   w_rem_next;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem_fix;

  assign w_a_neg     = i_a[WIDTH-1];
  assign w_b_neg     = i_b[WIDTH-1];
  assign w_mag_a     = w_a_neg ? -i_a : i_a;
  assign w_mag_b     = w_b_neg ? -i_b : i_b;
  assign w_start_dbz = i_op && (i_b == '0);

  // Shift-add: multiplier bit r_cnt selects |a| << r_cnt into the accumulator.
  assign w_addend   = r_opb[r_cnt] ? ({{WIDTH{1'b0}}, r_opa} << r_cnt) : '0;
  assign w_acc_next = r_acc + w_addend;

  // Restoring division: dividend bits leave the top of r_opa, quotient bits enter at the bottom.
  assign w_rem_sh   = {r_rem, r_opa[WIDTH-1]};
  assign w_qbit     = (w_rem_sh >= {1'b0, r_opb});
  assign w_rem_next = w_qbit ? WIDTH'(w_rem_sh - {1'b0, r_opb}) : w_rem_sh[WIDTH-1:0];

  assign w_prod    = r_neg ? -r_acc : r_acc;
  assign w_quo     = r_neg ? -r_opa : r_opa;
  assign w_rem_fix = r_rem_neg ? -r_rem : r_rem;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (i_start) w_next = S_CALC;
      S_CALC: begin
        if (r_dbz) begin
          w_next = S_DONE;
        end else if (r_cnt == LAST_ITER) begin
          w_next = S_FIX;
        end
      end
      S_FIX:   w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // A zero divisor spends one cycle in CALC with the iteration datapath idle, then loads results.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_op      <= 1'b0;
      r_neg     <= 1'b0;
      r_rem_neg <= 1'b0;
      r_dbz     <= 1'b0;
      r_opa     <= '0;
      r_opb     <= '0;
      r_acc     <= '0;
      r_rem     <= '0;
      r_cnt     <= '0;
      r_lo      <= '0;
      r_hi      <= '0;
      r_dz_out  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_op      <= i_op;
            r_opa     <= w_start_dbz ? i_a : w_mag_a;
            r_opb     <= w_mag_b;
            r_neg     <= w_a_neg ^ w_b_neg;
            r_rem_neg <= w_a_neg;
            r_dbz     <= w_start_dbz;
            r_acc     <= '0;
            r_rem     <= '0;
            r_cnt     <= '0;
          end
        end
        S_CALC: begin
          if (r_dbz) begin
            r_lo     <= '1;
            r_hi     <= r_opa;
            r_dz_out <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
            if (!r_op) begin
              r_acc <= w_acc_next;
            end else begin
              r_rem <= w_rem_next;
              r_opa <= {r_opa[WIDTH-2:0], w_qbit};
            end
          end
        end
        S_FIX: begin
          if (!r_op) begin
            r_lo <= w_prod[WIDTH-1:0];
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
          end else begin
            r_lo <= w_quo;
            r_hi <= w_rem_fix;
          end
          r_dz_out <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  assign o_busy        = (r_state != S_IDLE);
  assign o_done        = (r_state == S_DONE);
  assign o_result_lo   = r_lo;
  assign o_result_hi   = r_hi;
  assign o_div_by_zero = r_dz_out;

endmodule

// File: tb/tb_mul_div_unit.sv
// Randomized scoreboard bench for mul_div_unit against an integer-arithmetic reference model.
module tb_mul_div_unit;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        op    = 1'b0;
  logic [15:0] a     = '0;
  logic [15:0] b     = '0;
  logic        busy;
  logic        done;
  logic [15:0] result_lo;
  logic [15:0] result_hi;
  logic        div_by_zero;

  mul_div_unit #(.WIDTH(16)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (start),
    .i_op          (op),
    .i_a           (a),
    .i_b           (b),
    .o_busy        (busy),
    .o_done        (done),
    .o_result_lo   (result_lo),
    .o_result_hi   (result_hi),
    .o_div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] lo;
    logic [15:0] hi;
    logic        dz;
    int          due;
  } exp_t;

  exp_t q[$];
  exp_t acc_e;
  int   cyc       = 0;
  int   next_free = 0;
  int   busy_end  = 0;
  int   n_chk     = 0;
  int   n_pass    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
  endtask

  function automatic exp_t model(input logic o, input logic [15:0] x, input logic [15:0] y, input int now);
    exp_t e;
    int   sx, sy, p, qq, rr;
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (!o) begin
      p    = sx * sy;
      e.lo = p[15:0];
      e.hi = p[31:16];
      e.dz = 1'b0;
      e.due = now + 17;
    end else if (sy == 0) begin
      e.lo = 16'hFFFF;
      e.hi = x;
      e.dz = 1'b1;
      e.due = now + 1;
    end else begin
      qq   = sx / sy;
      rr   = sx % sy;
      e.lo = qq[15:0];
      e.hi = rr[15:0];
      e.dz = 1'b0;
      e.due = now + 17;
    end
    return e;
  endfunction

  // Reference timing: busy from the accepting edge until 18 (or 2) edges later, idle one cycle after.
  always @(posedge clk) begin
    cyc++;
    if (rst_n && start && cyc >= next_free) begin
      acc_e = model(op, a, b, cyc);
      q.push_back(acc_e);
      busy_end  = acc_e.dz ? cyc + 2 : cyc + 18;
      next_free = busy_end + 1;
    end
  end

  always @(negedge rst_n) begin
    q.delete();
    busy_end  = 0;
    next_free = 0;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      logic exp_done;
      exp_done = (q.size() > 0) && (q[0].due == cyc);
      check("done", {31'b0, done}, {31'b0, exp_done});
      check("busy", {31'b0, busy}, {31'b0, (cyc < busy_end)});
      if (done && exp_done) begin
        check("result_lo", {16'b0, result_lo}, {16'b0, q[0].lo});
        check("result_hi", {16'b0, result_hi}, {16'b0, q[0].hi});
        check("div_by_zero", {31'b0, div_by_zero}, {31'b0, q[0].dz});
        void'(q.pop_front());
      end else if (q.size() > 0 && q[0].due < cyc) begin
        n_chk++;
        $display("FAIL timeout at cycle %0d: no done, required by cycle %0d", cyc, q[0].due);
        void'(q.pop_front());
      end
    end
  end

  task automatic issue(input logic o, input logic [15:0] x, input logic [15:0] y);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    op = 1'($urandom);
    a  = 16'($urandom);
    b  = 16'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_done"}, {31'b0, done}, 32'd0);
    check({tag, "_lo"}, {16'b0, result_lo}, 32'd0);
    check({tag, "_hi"}, {16'b0, result_hi}, 32'd0);
    check({tag, "_dz"}, {31'b0, div_by_zero}, 32'd0);
  endtask

  initial begin
    idle(3);
    check_zero_outputs("reset");
    @(posedge clk);
    #3 rst_n = 1'b1;
    idle(5);

    issue(1'b0, 16'd3, 16'hFFFC);       idle(20);
    issue(1'b0, 16'h8000, 16'h8000);    idle(20);
    issue(1'b1, 16'd100, 16'd7);        idle(20);
    issue(1'b1, 16'hFFF9, 16'd2);       idle(20);
    issue(1'b1, 16'h8000, 16'hFFFF);    idle(20);
    issue(1'b1, 16'h1234, 16'h0000);    idle(4);
    issue(1'b0, 16'd5, 16'd5);          idle(20);
    issue(1'b1, 16'h7FFF, 16'h8000);    idle(20);

    // Start held high while operands churn every cycle.
    @(negedge clk);
    start = 1'b1;
    repeat (90) begin
      @(negedge clk);
      op = 1'($urandom);
      a  = 16'($urandom);
      b  = ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom);
    end
    start = 1'b0;
    idle(22);

    repeat (40) begin
      issue(1'($urandom),
            ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom),
            ($urandom_range(0, 5) == 0) ? 16'h0000 :
            ($urandom_range(0, 5) == 0) ? 16'hFFFF : 16'($urandom));
      idle($urandom_range(0, 22));
    end
    idle(22);

    // Abort a multiply mid-iteration after a result has been loaded.
    issue(1'b0, 16'h0123, 16'h0456);    idle(20);
    issue(1'b0, 16'h1357, 16'h0246);
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero_outputs("abort");
    @(posedge clk);
    #3 rst_n = 1'b1;
    idle(3);
    issue(1'b0, 16'hFED4, 16'd77);      idle(22);

    check("drain", q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
